// File: rtl/led_ind_pkg.sv
// led_ind_pkg: level encoding and LED pattern constants for the multi-channel level indicator.
package led_ind_pkg;
  typedef enum logic [2:0] {OFF, LOW, MID, HIGH, OVER} level_t;
  localparam logic [2:0] PAT_OFF  = 3'b000;
  localparam logic [2:0] PAT_LOW  = 3'b010;
  localparam logic [2:0] PAT_MID  = 3'b110;
  localparam logic [2:0] PAT_HIGH = 3'b100;
  localparam logic [2:0] PAT_OVER = 3'b001;
  function automatic logic [2:0] level_to_pat(level_t level, logic blink_phase);
    return level == LOW  ? PAT_LOW  :
           level == MID  ? PAT_MID  :
           level == HIGH ? PAT_HIGH :
           (level == OVER && blink_phase) ? PAT_OVER : PAT_OFF;
  endfunction
endpackage

// File: rtl/led_ind_channel.sv
// led_ind_channel: per-channel level hold, over/stale flags, idle timeout and registered LED pattern.
module led_ind_channel
  import led_ind_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic [2:0] level_in,
  input  logic       phase,
  output logic [2:0] led,
  output logic       over,
  output logic       stale
);
  level_t level, level_d;
  logic hit;
  generate
    if (TIMEOUT > 0) begin : g_to
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] cnt;
      always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= accept ? '0 : (cnt == TW'(TIMEOUT)) ? cnt : cnt + 1'b1;
      // A sample arriving on the expiring cycle wins over the timeout.
      assign hit = !accept && cnt == TW'(TIMEOUT - 1);
    end else begin : g_no_to
      assign hit = 1'b0;
    end
  endgenerate
  always_comb level_d = accept ? level_t'(level_in) : hit ? OFF : level;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level <= OFF;
      led   <= PAT_OFF;
      over  <= 1'b0;
      stale <= 1'b1;
    end else begin
      level <= level_d;
      led   <= level_to_pat(level_d, phase);
      over  <= level_d == OVER;
      stale <= accept ? 1'b0 : hit ? 1'b1 : stale;
    end
endmodule

// File: rtl/led_level_indicator.sv
// led_level_indicator: classifies (channel, value) samples into per-channel LED levels with blink and timeout.
module led_level_indicator
  import led_ind_pkg::*;
#(
  parameter int  DATA_W    = 8,
  parameter int  N_CH      = 4,
  parameter int  TH0       = 5,
  parameter int  TH1       = 10,
  parameter int  TH2       = 15,
  parameter int  TIMEOUT   = 0,
  parameter int  BLINK_DIV = 1024,
  localparam int CH_W      = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic [3*N_CH-1:0] led_out,
  output logic [N_CH-1:0]   over,
  output logic [N_CH-1:0]   stale,
  output logic              ch_err
);
  localparam int PW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [PW-1:0] pre;
  logic phase, wrap, phase_nxt;
  level_t lvl;
  assign wrap = pre == PW'(BLINK_DIV - 1);
  // Channels register the phase of the coming cycle so their pattern lines up with it.
  assign phase_nxt = phase ^ wrap;
  always_comb
    lvl = in_data <= DATA_W'(TH0) ? LOW :
          in_data <= DATA_W'(TH1) ? MID :
          in_data <= DATA_W'(TH2) ? HIGH : OVER;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre    <= '0;
      phase  <= 1'b0;
      ch_err <= 1'b0;
    end else begin
      pre    <= wrap ? '0 : pre + 1'b1;
      phase  <= phase_nxt;
      ch_err <= in_valid && 32'(in_ch) >= N_CH;
    end
  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      led_ind_channel #(.TIMEOUT(TIMEOUT)) u_ch (
        .clk     (clk),
        .rst     (rst),
        .accept  (in_valid && in_ch == CH_W'(i)),
        .level_in(lvl),
        .phase   (phase_nxt),
        .led     (led_out[3*i +: 3]),
        .over    (over[i]),
        .stale   (stale[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_led_level_indicator.sv
// tb_led_level_indicator: directed table plus corner sequences for the LED level indicator.
module tb_led_level_indicator;
  typedef struct {
    logic       v;
    logic [1:0] ch;
    logic [7:0] d;
    logic [8:0] led;
    logic [2:0] st;
  } vec_t;
  logic       clk = 0, rst = 1, in_valid = 0;
  logic [1:0] in_ch = 0;
  logic [7:0] in_data = 0;
  logic [8:0] led_out;
  logic [2:0] over, stale;
  logic       ch_err;
  int n_chk = 0, n_fail = 0, cyc = 0;
  vec_t vt[13];

  led_level_indicator #(
    .DATA_W(8), .N_CH(3), .TH0(5), .TH1(10), .TH2(15), .TIMEOUT(16), .BLINK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .led_out(led_out), .over(over), .stale(stale), .ch_err(ch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] ch, logic [7:0] d);
    in_valid = v;
    in_ch    = ch;
    in_data  = d;
  endtask

  task automatic send(logic [1:0] ch, logic [7:0] d);
    drive(1'b1, ch, d);
    tick();
    drive(1'b0, 2'd0, 8'd0);
  endtask

  // Expected over-range pattern after the m-th edge since reset release (phase flips every 4 edges).
  function automatic logic [2:0] blink(int m);
    return ((m / 4) % 2) != 0 ? 3'b001 : 3'b000;
  endfunction

  initial begin
    vt = '{
      '{1'b1, 2'd1, 8'd0,   9'b000_010_000, 3'b101},
      '{1'b1, 2'd1, 8'd5,   9'b000_010_000, 3'b101},
      '{1'b1, 2'd1, 8'd6,   9'b000_110_000, 3'b101},
      '{1'b1, 2'd1, 8'd10,  9'b000_110_000, 3'b101},
      '{1'b1, 2'd1, 8'd11,  9'b000_100_000, 3'b101},
      '{1'b1, 2'd1, 8'd15,  9'b000_100_000, 3'b101},
      '{1'b1, 2'd0, 8'd3,   9'b000_100_010, 3'b100},
      '{1'b1, 2'd2, 8'd12,  9'b100_100_010, 3'b000},
      '{1'b0, 2'd3, 8'd255, 9'b100_100_010, 3'b000},
      '{1'b0, 2'd2, 8'd200, 9'b100_100_010, 3'b000},
      '{1'b1, 2'd0, 8'd10,  9'b100_100_110, 3'b000},
      '{1'b1, 2'd1, 8'd1,   9'b100_010_110, 3'b000},
      '{1'b1, 2'd2, 8'd4,   9'b010_010_110, 3'b000}
    };
    // Reset state, then a long idle stretch
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {led_out, over, stale, ch_err}, {9'b0, 3'b000, 3'b111, 1'b0});
    @(negedge clk) rst = 0;
    cyc = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk($sformatf("idle%0d", k), {led_out, over, stale, ch_err}, {9'b0, 3'b000, 3'b111, 1'b0});
    end
    // Classification table
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].v, vt[i].ch, vt[i].d);
      tick();
      chk($sformatf("vec%0d", i), {led_out, over, stale, ch_err}, {vt[i].led, 3'b000, vt[i].st, 1'b0});
    end
    drive(1'b0, 2'd0, 8'd0);
    // Over-range blink on ch2, then back to LOW
    send(2'd2, 8'd16);
    chk("over16", {over[2], led_out[8:6]}, {1'b1, blink(cyc)});
    send(2'd2, 8'd255);
    chk("over255", {over[2], led_out[8:6]}, {1'b1, blink(cyc)});
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("blink%0d", k), {over[2], led_out[8:6]}, {1'b1, blink(cyc)});
    end
    send(2'd2, 8'd3);
    chk("over_clr", {over[2], led_out[8:6]}, {1'b0, 3'b010});
    // Timeout on ch0
    send(2'd0, 8'd7);
    chk("to_start", {stale[0], led_out[2:0]}, {1'b0, 3'b110});
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("to_idle%0d", k), {stale[0], led_out[2:0]}, {1'b0, 3'b110});
    end
    tick();
    chk("to_hit", {stale[0], over[0], led_out[2:0]}, {1'b1, 1'b0, 3'b000});
    send(2'd0, 8'd7);
    repeat (15) tick();
    drive(1'b1, 2'd0, 8'd7);
    tick();
    drive(1'b0, 2'd0, 8'd0);
    chk("to_race", {stale[0], led_out[2:0]}, {1'b0, 3'b110});
    repeat (15) tick();
    chk("to_race15", stale[0], 1'b0);
    tick();
    chk("to_race16", {stale[0], led_out[2:0]}, {1'b1, 3'b000});
    // Timeout also clears an over-range channel
    send(2'd2, 8'd200);
    chk("to_over0", over[2], 1'b1);
    repeat (15) tick();
    chk("to_over15", over[2], 1'b1);
    tick();
    chk("to_over16", {over[2], stale[2], led_out[8:6]}, {1'b0, 1'b1, 3'b000});
    // Out-of-range channel
    send(2'd0, 8'd3);
    send(2'd1, 8'd8);
    send(2'd2, 8'd13);
    chk("err_pre", {led_out, over, stale, ch_err}, {9'b100_110_010, 3'b000, 3'b000, 1'b0});
    send(2'd3, 8'd7);
    chk("err_pulse", {led_out, over, stale, ch_err}, {9'b100_110_010, 3'b000, 3'b000, 1'b1});
    tick();
    chk("err_end", ch_err, 1'b0);
    drive(1'b1, 2'd3, 8'd7);
    tick();
    chk("err_b2b0", ch_err, 1'b1);
    drive(1'b1, 2'd3, 8'd9);
    tick();
    chk("err_b2b1", ch_err, 1'b1);
    drive(1'b0, 2'd0, 8'd0);
    tick();
    chk("err_b2b_end", {led_out, over, stale, ch_err}, {9'b100_110_010, 3'b000, 3'b000, 1'b0});
    // Asynchronous reset mid-blink
    send(2'd0, 8'd3);
    send(2'd2, 8'd200);
    for (int k = 0; k < 8 && blink(cyc + 1) == 3'b000; k++) tick();
    drive(1'b1, 2'd3, 8'd0);
    tick();
    drive(1'b0, 2'd0, 8'd0);
    chk("pre_rst", {led_out[8:6], led_out[2:0], over[2], ch_err}, {3'b001, 3'b010, 1'b1, 1'b1});
    #2 rst = 1;
    #1;
    chk("async_rst", {led_out, over, stale, ch_err}, {9'b0, 3'b000, 3'b111, 1'b0});
    @(posedge clk);
    @(negedge clk) rst = 0;
    cyc = 0;
    send(2'd2, 8'd200);
    chk("restart0", {over[2], led_out[8:6]}, {1'b1, blink(cyc)});
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("restart%0d", k + 1), {over[2], led_out[8:6]}, {1'b1, blink(cyc)});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
